// File: rtl/gpio_ctrl_if.sv
// Data-memory bus bundle for gpio_ctrl: write strobe, word address, write data
// and the combinational read-data return path.
interface gpio_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 1
);
    logic              we;
    logic [CH_W+1:0]   a;
    logic [WIDTH-1:0]  wd;
    logic [WIDTH-1:0]  rd;

    modport master (output we, a, wd, input rd);
    modport slave  (input we, a, wd, output rd);
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: 2**CH_W channels of sync2 input, DOUT, IEN and W1C ISTAT.
// Optional macro GPIO_FALL_EDGE_EN adds a write-only per-bit ECFG edge-polarity register at offset 0.
module gpio_ctrl #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    gpio_ctrl_if.slave                    bus,
    input  logic [(2**CH_W)*WIDTH-1:0]    gpi,
    output logic [(2**CH_W)*WIDTH-1:0]    gpo,
    output logic                          irq
);
    localparam int NCH = 2**CH_W;

    logic [NCH*WIDTH-1:0] sync1, sync2, prev;
    logic [WIDTH-1:0]     dout      [NCH];
    logic [WIDTH-1:0]     ien       [NCH];
    logic [WIDTH-1:0]     istat     [NCH];
    logic [WIDTH-1:0]     istat_nxt [NCH];
    logic [WIDTH-1:0]     edge_ev   [NCH];
    logic [WIDTH-1:0]     w1c_mask  [NCH];
`ifdef GPIO_FALL_EDGE_EN
    logic [WIDTH-1:0]     ecfg      [NCH];
`endif
    logic [1:0]           prime;
    logic                 primed;
    logic [CH_W-1:0]      sel_ch;
    logic [1:0]           sel_reg;
    logic [WIDTH-1:0]     rd_word;

    assign sel_ch  = bus.a[CH_W+1:2];
    assign sel_reg = bus.a[1:0];
    // Inputs already high at reset would look like edges until prev catches up.
    assign primed  = (prime == 2'd3);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
`ifdef GPIO_FALL_EDGE_EN
            edge_ev[c] = (sync2[c*WIDTH +: WIDTH] & ~prev[c*WIDTH +: WIDTH] & ~ecfg[c])
                       | (~sync2[c*WIDTH +: WIDTH] & prev[c*WIDTH +: WIDTH] & ecfg[c]);
`else
            edge_ev[c] = sync2[c*WIDTH +: WIDTH] & ~prev[c*WIDTH +: WIDTH];
`endif
            w1c_mask[c]  = (bus.we && sel_ch == CH_W'(c) && sel_reg == 2'd3) ? bus.wd : '0;
            istat_nxt[c] = (istat[c] & ~w1c_mask[c]) | (primed ? edge_ev[c] : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            prime <= 2'd0;
            for (int c = 0; c < NCH; c++) begin
                dout[c]  <= '0;
                ien[c]   <= '0;
                istat[c] <= '0;
`ifdef GPIO_FALL_EDGE_EN
                ecfg[c]  <= '0;
`endif
            end
        end else begin
            sync1 <= gpi;
            sync2 <= sync1;
            prev  <= sync2;
            if (!primed)
                prime <= prime + 2'd1;
            for (int c = 0; c < NCH; c++) begin
                if (bus.we && sel_ch == CH_W'(c)) begin
                    case (sel_reg)
`ifdef GPIO_FALL_EDGE_EN
                        2'd0:    ecfg[c] <= bus.wd;
`endif
                        2'd1:    dout[c] <= bus.wd;
                        2'd2:    ien[c]  <= bus.wd;
                        default: ;
                    endcase
                end
                istat[c] <= istat_nxt[c];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        case (sel_reg)
            2'd0:    rd_word = sync2[int'(sel_ch)*WIDTH +: WIDTH];
            2'd1:    rd_word = dout[sel_ch];
            2'd2:    rd_word = ien[sel_ch];
            default: rd_word = istat[sel_ch];
        endcase
    end
    assign bus.rd = rd_word;

    always_comb begin
        irq = 1'b0;
        gpo = '0;
        for (int c = 0; c < NCH; c++) begin
            gpo[c*WIDTH +: WIDTH] = dout[c];
            irq = irq | (|(istat[c] & ien[c]));
        end
    end
endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised, memory-mapped GPIO controller for the MIPS32 data-memory bus. It is the next generation of the two-port GPIO block and provides 2**CH_W output/input channel pairs of WIDTH bits. Each channel adds:
- two-flop input synchronisation,
- rising-edge capture into sticky write-1-to-clear status bits,
- per-bit interrupt enables, combined into one interrupt line.
Reads are combinational in the same cycle, matching the single-cycle memory stage; writes take effect at the clock edge.

Parameters:
WIDTH, 32, bits per channel and bus data width
CH_W, 1, log2 of channel count; NCH = 2**CH_W (channels 0..NCH-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
we  input  1  bus write strobe, sampled at rising clk
a  input  CH_W+2  word address: a[CH_W+1:2] = channel, a[1:0] = register
wd  input  WIDTH  write data
rd  output  WIDTH  read data (combinational from a and internal registers)
gpi  input  NCH*WIDTH  asynchronous inputs; channel c occupies bits [c*WIDTH +: WIDTH]
gpo  output  NCH*WIDTH  output registers, same packing as gpi
irq  output  1  level interrupt = OR over channels of |(ISTAT[c] & IEN[c])

Behaviour:
- Register map per channel (a[1:0]):
  - 0 DIN: read-only, sync2 stage; writes ignored.
  - 1 DOUT: read/write; drives gpo.
  - 2 IEN: read/write.
  - 3 ISTAT: read returns status; write clears the bits where wd=1 (W1C).
- Reset (rst=1 at clk edge) clears all of the following to 0: sync1, sync2, prev, DOUT, IEN, ISTAT, and the prime counter. After that edge, gpo=0, irq=0, and rd for DIN/DOUT/IEN/ISTAT reads 0. Reset overrides any write in the same cycle.
- Synchroniser, every cycle:
  - sync1 <= gpi
  - sync2 <= sync1
  - prev <= sync2
- Latency: if gpi is stable before edge k, sync1 captures at k, DIN shows the new value after edge k+1, and the edge is detected and the ISTAT bit set at edge k+2. irq asserts after edge k+2 when IEN=1. There is no additional register on irq.
- Rising edge per bit: rise = sync2 & ~prev.
- Prime counter (2-bit, saturating at 3): increments each cycle after reset. Edge capture is enabled only when the count is 3. This suppresses false edges from inputs that are already high at reset.
- ISTAT update per bit: next = (ISTAT & ~(w1c_mask)) | (rise & primed).
  - When a W1C write and a new edge hit the same bit in the same cycle, set wins and the bit stays 1.
  - ISTAT captures regardless of IEN. IEN masks only irq.
- Write decode: we=1 affects only the channel selected by a[CH_W+1:2] and the register selected by a[1:0]. Other channels are unchanged.
- DOUT write: gpo channel takes wd after the edge. Reading DOUT in the same cycle returns the old value.
- Read decode: rd = selected register of the selected channel. There are no undefined addresses because NCH is a power of two.
- irq: the level stays high while any enabled status bit is 1. Clearing through W1C or IEN=0 drops irq after that edge.

Optional Feature:
GPIO_FALL_EDGE_EN
- When defined, each channel adds an ECFG register that replaces read-only DIN at a[1:0]=0 for writes only. Reads at offset 0 still return DIN; ECFG is write-only there.
  - Per bit, ECFG=0 selects rising-edge capture and ECFG=1 selects falling-edge capture (fall = ~sync2 & prev).
  - ECFG resets to 0.
- When undefined, only rising edges are captured and writes to offset 0 are ignored.

Test Plan:
- Reset/defaults: assert rst 2 cycles with gpi=32'hFFFF_FFFF on ch0, then release. Required: gpo=0, irq=0, and ISTAT ch0 reads 0 for 10 cycles, because the prime counter suppresses the edge.
- DOUT write/readback: we=1, a=5 (ch1 DOUT), wd=32'hA5A5_0F0F. Required: gpo[63:32]=32'hA5A5_0F0F after the edge, gpo[31:0] unchanged, and rd at a=5 returns the value.
- Sync latency: after priming, set IEN ch0 = 32'h1, then drive gpi[0] 0->1 before edge k. Required: DIN bit0 reads 1 after edge k+1, ISTAT bit0 = 1 and irq = 1 after edge k+2.
- W1C collision: with ISTAT ch0 bit3 = 1, write a=3 with wd=32'h8 in the same cycle that a new rise on bit3 is detected. Required: bit3 stays 1. A W1C with no new edge clears it and irq falls on the next edge.
- Masking across channels: rise on ch1 bit7 with IEN ch1 = 0. Required: ISTAT ch1 reads 32'h80 and irq=0. Then write IEN ch1 = 32'h80. Required: irq=1 after the edge.
- GPIO_FALL_EDGE_EN build: ECFG ch0 = 32'h1, drive gpi[0] 1->0. Required: ISTAT bit0 = 1 after the edge at k+2. A 0->1 transition on bit0 sets nothing.
